// File: rtl/age_ordered_reservation_station_pkg.sv
// age_ordered_reservation_station_pkg: shared types and defaults for the reservation station slice.
package age_ordered_reservation_station_pkg;
    localparam int RS_ID_WIDTH_DEFAULT   = 5;
    localparam int OPERAND_WIDTH_DEFAULT = 32;
    localparam int CDB_PORTS_DEFAULT     = 2;

    typedef struct packed {
        logic                             valid;
        logic [RS_ID_WIDTH_DEFAULT-1:0]   rs_id;
        logic [OPERAND_WIDTH_DEFAULT-1:0] value;
    } rs_cdb_t;

    typedef struct packed {
        logic       subtract;
        logic       carry_in;
        logic       carry_out_en;
        logic       record_cr;
        logic [3:0] dest;
    } add_sub_decode_t;
endpackage

// File: rtl/age_ordered_reservation_station_if.sv
// age_ordered_reservation_station_if: take, CDB and dispatch signals of the reservation station.
interface age_ordered_reservation_station_if
    import age_ordered_reservation_station_pkg::*;
#(
    parameter int  OPERANDS      = 2,
    parameter int  OPERAND_WIDTH = OPERAND_WIDTH_DEFAULT,
    parameter int  RS_ID_WIDTH   = RS_ID_WIDTH_DEFAULT,
    parameter int  CDB_PORTS     = CDB_PORTS_DEFAULT,
    parameter int  RS_DEPTH      = 8,
    parameter type CONTROL_TYPE  = add_sub_decode_t
);
    logic                                        flush;
    logic                                        take_valid;
    logic                                        take_ready;
    logic [OPERANDS-1:0]                         op_value_valid_in;
    logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]        op_rs_id_in;
    logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]      op_value_in;
    CONTROL_TYPE                                 control_in;
    logic [RS_ID_WIDTH-1:0]                      id_taken;
    logic [CDB_PORTS-1:0]                        cdb_valid;
    logic [CDB_PORTS-1:0][RS_ID_WIDTH-1:0]       cdb_rs_id;
    logic [CDB_PORTS-1:0][OPERAND_WIDTH-1:0]     cdb_value;
    logic                                        output_valid;
    logic                                        output_ready;
    logic [OPERANDS-1:0][OPERAND_WIDTH-1:0]      op_value_out;
    CONTROL_TYPE                                 control_out;
    logic [RS_ID_WIDTH-1:0]                      op_rs_id_out;
    logic [$clog2(RS_DEPTH+1)-1:0]               occupancy;

    modport master (
        output flush, take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
               cdb_valid, cdb_rs_id, cdb_value, output_ready,
        input  take_ready, id_taken, output_valid, op_value_out, control_out, op_rs_id_out, occupancy
    );
    modport slave (
        input  flush, take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
               cdb_valid, cdb_rs_id, cdb_value, output_ready,
        output take_ready, id_taken, output_valid, op_value_out, control_out, op_rs_id_out, occupancy
    );
endinterface

// File: rtl/age_ordered_reservation_station_rs_age_matrix.sv
// rs_age_matrix: tracks relative entry age and grants the oldest requester.
// age[i][j]=1 means entry i is older than entry j.
module rs_age_matrix #(
    parameter int RS_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_en,
    input  logic [$clog2(RS_DEPTH)-1:0] alloc_idx,
    input  logic [RS_DEPTH-1:0]         dealloc,
    input  logic                        flush,
    input  logic [RS_DEPTH-1:0]         req,
    output logic [RS_DEPTH-1:0]         grant
);
    logic [RS_DEPTH-1:0] age [RS_DEPTH];
    logic [RS_DEPTH-1:0] valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            age   <= '{default: '0};
        end else if (flush) begin
            valid <= '0;
        end else begin
            valid <= (valid & ~dealloc) | (alloc_en ? RS_DEPTH'(1) << alloc_idx : '0);
            if (alloc_en)
                for (int j = 0; j < RS_DEPTH; j++) begin
                    age[alloc_idx][j] <= 1'b0;
                    age[j][alloc_idx] <= valid[j];
                end
        end
    end

    always_comb begin
        grant = req;
        for (int i = 0; i < RS_DEPTH; i++)
            for (int j = 0; j < RS_DEPTH; j++)
                if (req[j] && age[j][i]) grant[i] = 1'b0;
    end
endmodule

// File: rtl/age_ordered_reservation_station.sv
// age_ordered_reservation_station: operand-capturing reservation station dispatching one ready entry per cycle.
// RS_AGE_ORDER_EN selects oldest-ready dispatch; otherwise the lowest-index ready entry goes first.
module age_ordered_reservation_station
    import age_ordered_reservation_station_pkg::*;
#(
    parameter int  OPERANDS      = 2,
    parameter int  OPERAND_WIDTH = 32,
    parameter int  RS_OFFSET     = 0,
    parameter int  RS_DEPTH      = 8,
    parameter int  RS_ID_WIDTH   = 5,
    parameter int  CDB_PORTS     = 2,
    parameter type CONTROL_TYPE  = add_sub_decode_t
) (
    input logic clk,
    input logic rst,
    age_ordered_reservation_station_if.slave rs
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int OCC_W = $clog2(RS_DEPTH+1);

    logic [RS_DEPTH-1:0]      valid, ready, alloc_oh, grant;
    logic [OPERANDS-1:0]      opv [RS_DEPTH];
    logic [RS_ID_WIDTH-1:0]   tag [RS_DEPTH][OPERANDS];
    logic [OPERAND_WIDTH-1:0] val [RS_DEPTH][OPERANDS];
    CONTROL_TYPE              ctrl [RS_DEPTH];
    logic [IDX_W-1:0]         alloc_idx, sel_idx;
    logic [OPERANDS-1:0]      cap_v;
    logic [OPERAND_WIDTH-1:0] cap_val [OPERANDS];
    logic [OCC_W-1:0]         occ;
    logic                     take, disp;

    assign alloc_oh        = ~valid & (valid + RS_DEPTH'(1));
    assign take            = rs.take_valid & ~&valid & ~rs.flush;
    assign disp            = rs.output_valid & rs.output_ready;
    assign rs.take_ready   = ~&valid;
    assign rs.id_taken     = RS_ID_WIDTH'(alloc_idx) + RS_ID_WIDTH'(RS_OFFSET);
    assign rs.output_valid = |ready & ~rs.flush;
    assign rs.control_out  = ctrl[sel_idx];
    assign rs.op_rs_id_out = RS_ID_WIDTH'(sel_idx) + RS_ID_WIDTH'(RS_OFFSET);
    assign rs.occupancy    = occ;

    always_comb begin
        alloc_idx = '0;
        sel_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready[i] = valid[i] & &opv[i];
            if (alloc_oh[i]) alloc_idx = IDX_W'(i);
            if (grant[i]) sel_idx = IDX_W'(i);
        end
        // descending scan so the lowest matching CDB port wins
        for (int o = 0; o < OPERANDS; o++) begin
            cap_v[o]           = rs.op_value_valid_in[o];
            cap_val[o]         = rs.op_value_in[o];
            rs.op_value_out[o] = val[sel_idx][o];
            for (int p = CDB_PORTS-1; p >= 0; p--)
                if (!rs.op_value_valid_in[o] && rs.cdb_valid[p] && rs.cdb_rs_id[p] == rs.op_rs_id_in[o]) begin
                    cap_v[o]   = 1'b1;
                    cap_val[o] = rs.cdb_value[p];
                end
        end
    end

`ifdef RS_AGE_ORDER_EN
    rs_age_matrix #(.RS_DEPTH(RS_DEPTH)) u_age (
        .clk      (clk),
        .rst      (rst),
        .alloc_en (take),
        .alloc_idx(alloc_idx),
        .dealloc  (disp ? grant : '0),
        .flush    (rs.flush),
        .req      (ready),
        .grant    (grant)
    );
`else
    assign grant = ready & (~ready + RS_DEPTH'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            occ   <= '0;
        end else if (rs.flush) begin
            valid <= '0;
            occ   <= '0;
        end else begin
            occ <= occ + OCC_W'(take) - OCC_W'(disp);
            for (int i = 0; i < RS_DEPTH; i++) begin
                for (int o = 0; o < OPERANDS; o++)
                    for (int p = CDB_PORTS-1; p >= 0; p--)
                        if (valid[i] && !opv[i][o] && rs.cdb_valid[p] && rs.cdb_rs_id[p] == tag[i][o]) begin
                            opv[i][o] <= 1'b1;
                            val[i][o] <= rs.cdb_value[p];
                        end
                if (take && alloc_oh[i]) begin
                    valid[i] <= 1'b1;
                    ctrl[i]  <= rs.control_in;
                    opv[i]   <= cap_v;
                    for (int o = 0; o < OPERANDS; o++) begin
                        tag[i][o] <= rs.op_rs_id_in[o];
                        val[i][o] <= cap_val[o];
                    end
                end
                if (disp && grant[i]) valid[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_age_ordered_reservation_station.sv
// tb_age_ordered_reservation_station: directed and random checks against an allocation-order queue model.
module tb_age_ordered_reservation_station;
    import age_ordered_reservation_station_pkg::*;
    localparam int D   = 8;
    localparam int OFF = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    age_ordered_reservation_station_if #(
        .OPERANDS(2), .OPERAND_WIDTH(32), .RS_ID_WIDTH(5), .CDB_PORTS(2),
        .RS_DEPTH(D), .CONTROL_TYPE(add_sub_decode_t)
    ) rs ();

    age_ordered_reservation_station #(
        .OPERANDS(2), .OPERAND_WIDTH(32), .RS_OFFSET(OFF), .RS_DEPTH(D),
        .RS_ID_WIDTH(5), .CDB_PORTS(2), .CONTROL_TYPE(add_sub_decode_t)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rs (rs)
    );

    int total = 0;
    int bad   = 0;

    bit              m_busy [D];
    bit [1:0]        m_opv  [D];
    logic [4:0]      m_tag  [D][2];
    logic [31:0]     m_val  [D][2];
    add_sub_decode_t m_ctrl [D];
    int              q [$];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(int s);
        return m_busy[s] && (&m_opv[s]);
    endfunction

    // oldest ready by allocation order, or lowest ready slot without age ordering
    function automatic int m_sel();
`ifdef RS_AGE_ORDER_EN
        foreach (q[k]) if (m_ready(q[k])) return q[k];
`else
        for (int s = 0; s < D; s++) if (m_ready(s)) return s;
`endif
        return -1;
    endfunction

    function automatic int m_free();
        for (int s = 0; s < D; s++) if (!m_busy[s]) return s;
        return -1;
    endfunction

    function automatic bit cdb_hit(logic [4:0] t, output logic [31:0] v);
        v = '0;
        for (int p = 0; p < 2; p++)
            if (rs.cdb_valid[p] && rs.cdb_rs_id[p] == t) begin
                v = rs.cdb_value[p];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic step();
        int sel, fs;
        bit ev;
        logic [31:0] v;
        int idx [$];
        #1;
        check("take_ready", rs.take_ready, q.size() < D);
        check("occupancy", rs.occupancy, q.size());
        fs = m_free();
        if (fs >= 0) check("id_taken", rs.id_taken, fs + OFF);
        sel = m_sel();
        ev  = sel >= 0 && !rs.flush;
        check("output_valid", rs.output_valid, ev);
        if (ev) begin
            check("op_rs_id_out", rs.op_rs_id_out, sel + OFF);
            check("op_value_out0", rs.op_value_out[0], m_val[sel][0]);
            check("op_value_out1", rs.op_value_out[1], m_val[sel][1]);
            check("control_out", rs.control_out, m_ctrl[sel]);
        end
        if (rs.flush) begin
            foreach (m_busy[s]) m_busy[s] = 1'b0;
            q.delete();
        end else begin
            for (int s = 0; s < D; s++)
                if (m_busy[s])
                    for (int o = 0; o < 2; o++)
                        if (!m_opv[s][o] && cdb_hit(m_tag[s][o], v)) begin
                            m_opv[s][o] = 1'b1;
                            m_val[s][o] = v;
                        end
            if (ev && rs.output_ready) begin
                m_busy[sel] = 1'b0;
                idx = q.find_first_index(x) with (x == sel);
                q.delete(idx[0]);
            end
            if (rs.take_valid && fs >= 0) begin
                m_busy[fs] = 1'b1;
                m_ctrl[fs] = rs.control_in;
                for (int o = 0; o < 2; o++) begin
                    m_tag[fs][o] = rs.op_rs_id_in[o];
                    m_opv[fs][o] = rs.op_value_valid_in[o] || cdb_hit(rs.op_rs_id_in[o], v);
                    m_val[fs][o] = rs.op_value_valid_in[o] ? rs.op_value_in[o] : v;
                end
                q.push_back(fs);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rs.flush             = 1'b0;
        rs.take_valid        = 1'b0;
        rs.op_value_valid_in = '0;
        rs.op_rs_id_in       = '0;
        rs.op_value_in       = '0;
        rs.control_in        = '0;
        rs.cdb_valid         = '0;
        rs.cdb_rs_id         = '0;
        rs.cdb_value         = '0;
        rs.output_ready      = 1'b0;
    endtask

    task automatic drive_take(logic [1:0] vv, logic [4:0] t0, logic [4:0] t1, logic [31:0] v0, logic [31:0] v1);
        rs.take_valid        = 1'b1;
        rs.op_value_valid_in = vv;
        rs.op_rs_id_in[0]    = t0;
        rs.op_rs_id_in[1]    = t1;
        rs.op_value_in[0]    = v0;
        rs.op_value_in[1]    = v1;
        rs.control_in        = add_sub_decode_t'(8'($urandom));
    endtask

    task automatic rnd();
        rs.take_valid        = 1'($urandom);
        rs.op_value_valid_in = 2'($urandom);
        rs.control_in        = add_sub_decode_t'(8'($urandom));
        for (int o = 0; o < 2; o++) begin
            rs.op_rs_id_in[o] = 5'($urandom_range(0, 15));
            rs.op_value_in[o] = $urandom;
        end
        rs.cdb_valid = 2'($urandom);
        for (int p = 0; p < 2; p++) begin
            rs.cdb_rs_id[p] = 5'($urandom_range(0, 15));
            rs.cdb_value[p] = $urandom;
        end
        if (rs.cdb_rs_id[1] == rs.cdb_rs_id[0]) rs.cdb_rs_id[1] = rs.cdb_rs_id[0] ^ 5'd1;
        rs.output_ready = $urandom_range(0, 3) != 0;
        rs.flush        = $urandom_range(0, 60) == 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        #1;
        check("rst_take_ready", rs.take_ready, 1);
        check("rst_output_valid", rs.output_valid, 0);
        check("rst_id_taken", rs.id_taken, OFF);
        check("rst_op_rs_id_out", rs.op_rs_id_out, OFF);
        check("rst_occupancy", rs.occupancy, 0);
        rst = 1'b0;
        @(negedge clk);

        drive_take(2'b11, 5'd0, 5'd0, 32'd5, 32'd7);
        #1 check("t1_id_taken", rs.id_taken, 8);
        step(); idle();
        #1;
        check("t1_valid", rs.output_valid, 1);
        check("t1_op0", rs.op_value_out[0], 5);
        check("t1_op1", rs.op_value_out[1], 7);
        check("t1_id", rs.op_rs_id_out, 8);
        rs.output_ready = 1'b1;
        step(); idle();

        drive_take(2'b10, 5'd3, 5'd0, 32'd0, 32'd9);
        step(); idle();
        step();
        rs.cdb_valid = 2'b10; rs.cdb_rs_id[1] = 5'd3; rs.cdb_value[1] = 32'hAA;
        #1 check("t2_not_yet", rs.output_valid, 0);
        step(); idle();
        #1;
        check("t2_valid", rs.output_valid, 1);
        check("t2_op0", rs.op_value_out[0], 32'hAA);
        rs.output_ready = 1'b1;
        step(); idle();

        drive_take(2'b10, 5'd4, 5'd0, 32'd0, 32'd1);
        rs.cdb_valid = 2'b01; rs.cdb_rs_id[0] = 5'd4; rs.cdb_value[0] = 32'h55;
        step(); idle();
        #1;
        check("t3_valid", rs.output_valid, 1);
        check("t3_op0", rs.op_value_out[0], 32'h55);
        rs.output_ready = 1'b1;
        step(); idle();

        for (int i = 0; i < D; i++) begin
            drive_take(2'b10, 5'(10 + i), 5'd0, 32'd0, 32'(i));
            step(); idle();
        end
        #1;
        check("t4_full", rs.take_ready, 0);
        check("t4_occ", rs.occupancy, 8);
        rs.cdb_valid = 2'b11;
        rs.cdb_rs_id[0] = 5'd15; rs.cdb_value[0] = 32'h500;
        rs.cdb_rs_id[1] = 5'd12; rs.cdb_value[1] = 32'h200;
        rs.output_ready = 1'b1;
        step(); idle();
        rs.output_ready = 1'b1;
        #1 check("t4_first", rs.op_rs_id_out, OFF + 2);
        step();
        #1 check("t4_second", rs.op_rs_id_out, OFF + 5);
        step(); idle();

        rs.cdb_valid = 2'b01; rs.cdb_rs_id[0] = 5'd10; rs.cdb_value[0] = 32'h1234;
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            #1 check("t5_hold_id", rs.op_rs_id_out, OFF);
            check("t5_hold_op0", rs.op_value_out[0], 32'h1234);
            step();
        end
        rs.output_ready = 1'b1;
        step(); idle();
        #1 check("t5_occ", rs.occupancy, 5);

        rs.cdb_valid = 2'b01; rs.cdb_rs_id[0] = 5'd11; rs.cdb_value[0] = 32'h77;
        step(); idle();
        rs.output_ready = 1'b1;
        step(); idle();
        #1 check("t6_occ_before", rs.occupancy, 4);
        drive_take(2'b11, 5'd1, 5'd2, 32'd1, 32'd2);
        rs.flush = 1'b1;
        #1 check("t6_ov_flush", rs.output_valid, 0);
        step(); idle();
        #1;
        check("t6_occ", rs.occupancy, 0);
        check("t6_ov", rs.output_valid, 0);
        check("t6_take_ready", rs.take_ready, 1);

        repeat (3000) begin
            rnd();
            step();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
